// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown timer display controller:
//   - state_e      : FSM state codes as seen on actualState
//   - DIGIT_W      : width of one BCD digit
//   - BCD_MAX_UNIT : largest value of a units digit (and of the minute tens)
//   - BCD_MAX_TENS : largest value of the seconds tens digit
//   - bcd_clamp    : saturates a raw preset digit to a legal maximum
// ----------------------------------------------------------------------------
package timer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX_UNIT = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_e;

    // Saturate a preset digit so the display never holds a non-BCD value.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(
        input logic [DIGIT_W-1:0] i_digit,
        input logic [DIGIT_W-1:0] i_max
    );
        return (i_digit > i_max) ? i_max : i_digit;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Prescaler that turns the system clock into one-cycle countdown ticks.
// Counts 0..DIV-1 while enabled, flags o_tick in the cycle it sits at DIV-1,
// then wraps to 0. Holds its value while disabled.
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous active-high reset
//   i_en    : count enable
//   i_clr   : synchronous zero (wins over i_en)
//   o_tick  : high while enabled and the count is DIV-1
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int              CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);
    assign o_tick    = i_en && w_at_last;

    // Prescaler counter: zero on reset/clear, wrap at DIV-1, hold when idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_en) begin
            r_cnt <= w_at_last ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/timer_display_ctrl.sv
// ----------------------------------------------------------------------------
// timer_display_ctrl
// MM:SS BCD countdown timer with start/pause/clear/load commands, feeding a
// VGA painter with registered digits and state.
// Optional feature: define TIMER_AUTO_RELOAD_EN to reload the preset and keep
// running when the count reaches 00:00 (default build stops in DONE).
// Ports:
//   clk_100MHz          : system clock
//   reset               : synchronous active-high reset
//   start/pause/clear/load : one-cycle command pulses (clear > load > start/pause)
//   set_mDecimal..set_sUnit : preset digits, clamped and sampled on load
//   mDecimal..sUnit     : registered BCD display digits
//   actualState         : registered FSM state code
//   finish              : one-cycle pulse together with the 00:00 transition
// ----------------------------------------------------------------------------
module timer_display_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] set_mDecimal,
    input  logic [DIGIT_W-1:0] set_mUnit,
    input  logic [DIGIT_W-1:0] set_sDecimal,
    input  logic [DIGIT_W-1:0] set_sUnit,
    output logic [DIGIT_W-1:0] mDecimal,
    output logic [DIGIT_W-1:0] mUnit,
    output logic [DIGIT_W-1:0] sDecimal,
    output logic [DIGIT_W-1:0] sUnit,
    output logic [2:0]         actualState,
    output logic               finish
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    state_e             r_state, w_nstate;
    logic [DIGIT_W-1:0] r_md, r_mu, r_sd, r_su;
    logic [DIGIT_W-1:0] r_pmd, r_pmu, r_psd, r_psu;
    logic [DIGIT_W-1:0] w_md, w_mu, w_sd, w_su;
    logic [DIGIT_W-1:0] w_pmd, w_pmu, w_psd, w_psu;
    logic               r_finish, w_finish;

    logic               w_tick, w_pre_en, w_pre_clr, w_disp_nz;
    logic               w_b0, w_b1, w_b2, w_dec_zero;
    logic [DIGIT_W-1:0] w_dec_md, w_dec_mu, w_dec_sd, w_dec_su;

    // Counting only advances in RUN when nothing is about to leave RUN.
    // IDLE/DONE keep the prescaler at zero so every fresh start sees a full period.
    assign w_pre_en  = (r_state == RUN) && !clear && !pause;
    assign w_pre_clr = clear || ((r_state != RUN) && (r_state != PAUSE));

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk   (clk_100MHz),
        .i_reset (reset),
        .i_en    (w_pre_en),
        .i_clr   (w_pre_clr),
        .o_tick  (w_tick)
    );

    // Borrow chain: each digit wraps only when every lower digit wraps.
    assign w_b0     = (r_su == 4'd0);
    assign w_b1     = w_b0 && (r_sd == 4'd0);
    assign w_b2     = w_b1 && (r_mu == 4'd0);
    assign w_dec_su = w_b0 ? BCD_MAX_UNIT : (r_su - 4'd1);
    assign w_dec_sd = w_b0 ? ((r_sd == 4'd0) ? BCD_MAX_TENS : (r_sd - 4'd1)) : r_sd;
    assign w_dec_mu = w_b1 ? ((r_mu == 4'd0) ? BCD_MAX_UNIT : (r_mu - 4'd1)) : r_mu;
    assign w_dec_md = w_b2 ? (r_md - 4'd1) : r_md;
    assign w_dec_zero = ({w_dec_md, w_dec_mu, w_dec_sd, w_dec_su} == 16'h0000);
    assign w_disp_nz  = ({r_md, r_mu, r_sd, r_su} != 16'h0000);

`ifdef TIMER_AUTO_RELOAD_EN
    logic w_preset_nz;
    assign w_preset_nz = ({r_pmd, r_pmu, r_psd, r_psu} != 16'h0000);
`endif

    // Next-state, next-digit and finish decode with command priority.
    always_comb begin
        w_nstate = r_state;
        w_md     = r_md;
        w_mu     = r_mu;
        w_sd     = r_sd;
        w_su     = r_su;
        w_pmd    = r_pmd;
        w_pmu    = r_pmu;
        w_psd    = r_psd;
        w_psu    = r_psu;
        w_finish = 1'b0;
        if (clear) begin
            w_nstate = IDLE;
            w_md  = 4'd0;  w_mu  = 4'd0;  w_sd  = 4'd0;  w_su  = 4'd0;
            w_pmd = 4'd0;  w_pmu = 4'd0;  w_psd = 4'd0;  w_psu = 4'd0;
        end else if (load && (r_state != RUN)) begin
            w_nstate = IDLE;
            w_pmd = bcd_clamp(set_mDecimal, BCD_MAX_UNIT);
            w_pmu = bcd_clamp(set_mUnit,    BCD_MAX_UNIT);
            w_psd = bcd_clamp(set_sDecimal, BCD_MAX_TENS);
            w_psu = bcd_clamp(set_sUnit,    BCD_MAX_UNIT);
            w_md  = w_pmd;
            w_mu  = w_pmu;
            w_sd  = w_psd;
            w_su  = w_psu;
        end else begin
            case (r_state)
                IDLE, PAUSE: begin
                    if (start && w_disp_nz) begin
                        w_nstate = RUN;
                    end else begin
                        w_nstate = r_state;
                    end
                end
                RUN: begin
                    if (pause) begin
                        w_nstate = PAUSE;
                    end else if (w_tick) begin
                        w_md = w_dec_md;
                        w_mu = w_dec_mu;
                        w_sd = w_dec_sd;
                        w_su = w_dec_su;
                        if (w_dec_zero) begin
                            w_finish = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                            if (w_preset_nz) begin
                                w_nstate = RUN;
                                w_md = r_pmd;
                                w_mu = r_pmu;
                                w_sd = r_psd;
                                w_su = r_psu;
                            end else begin
                                w_nstate = DONE;
                            end
`else
                            w_nstate = DONE;
`endif
                        end else begin
                            w_nstate = RUN;
                        end
                    end else begin
                        w_nstate = RUN;
                    end
                end
                DONE: begin
                    w_nstate = DONE;
                end
                default: begin
                    w_nstate = IDLE;
                end
            endcase
        end
    end

    // State, digit, preset and finish registers.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state  <= IDLE;
            r_md     <= 4'd0;  r_mu  <= 4'd0;  r_sd  <= 4'd0;  r_su  <= 4'd0;
            r_pmd    <= 4'd0;  r_pmu <= 4'd0;  r_psd <= 4'd0;  r_psu <= 4'd0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_md     <= w_md;   r_mu  <= w_mu;   r_sd  <= w_sd;   r_su  <= w_su;
            r_pmd    <= w_pmd;  r_pmu <= w_pmu;  r_psd <= w_psd;  r_psu <= w_psu;
            r_finish <= w_finish;
        end
    end

    assign mDecimal    = r_md;
    assign mUnit       = r_mu;
    assign sDecimal    = r_sd;
    assign sUnit       = r_su;
    assign actualState = r_state;
    assign finish      = r_finish;

endmodule

// File: tb/tb_timer_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_display_ctrl
// Directed bench for timer_display_ctrl with CLK_HZ=10, TICK_HZ=1 (DIV=10).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// ----------------------------------------------------------------------------
module tb_timer_display_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, pause, clear, load;
    logic [3:0] set_mDecimal, set_mUnit, set_sDecimal, set_sUnit;
    logic [3:0] mDecimal, mUnit, sDecimal, sUnit;
    logic [2:0] actualState;
    logic       finish;
    logic [15:0] disp;

    int errors = 0;
    int checks = 0;

    assign disp = {mDecimal, mUnit, sDecimal, sUnit};

    timer_display_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk_100MHz   (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .clear        (clear),
        .load         (load),
        .set_mDecimal (set_mDecimal),
        .set_mUnit    (set_mUnit),
        .set_sDecimal (set_sDecimal),
        .set_sUnit    (set_sUnit),
        .mDecimal     (mDecimal),
        .mUnit        (mUnit),
        .sDecimal     (sDecimal),
        .sUnit        (sUnit),
        .actualState  (actualState),
        .finish       (finish)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        set_mDecimal = a; set_mUnit = b; set_sDecimal = c; set_sUnit = d;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp: got %h want 0000", disp); end
        checks++; if (actualState !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", actualState); end
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b want 0", finish); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_countdown();
        do_load(4'd0, 4'd0, 4'd0, 4'd3);
        checks++; if (disp !== 16'h0003) begin errors++; $display("FAIL cd_load: got %h want 0003", disp); end
        pulse_start();
        step(9);
        checks++; if (disp !== 16'h0003 || actualState !== 3'd1) begin errors++; $display("FAIL cd_c9: got %h st %0d want 0003 st 1", disp, actualState); end
        step(1);
        checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL cd_c10: got %h want 0002", disp); end
        step(10);
        checks++; if (disp !== 16'h0001 || finish !== 1'b0) begin errors++; $display("FAIL cd_c20: got %h fin %b want 0001 fin 0", disp, finish); end
        step(10);
`ifdef TIMER_AUTO_RELOAD_EN
        checks++; if (disp !== 16'h0003 || finish !== 1'b1 || actualState !== 3'd1) begin errors++; $display("FAIL cd_c30: got %h fin %b st %0d want 0003 fin 1 st 1", disp, finish, actualState); end
        step(1);
        checks++; if (finish !== 1'b0 || actualState !== 3'd1) begin errors++; $display("FAIL cd_c31: fin %b st %0d want fin 0 st 1", finish, actualState); end
`else
        checks++; if (disp !== 16'h0000 || finish !== 1'b1 || actualState !== 3'd3) begin errors++; $display("FAIL cd_c30: got %h fin %b st %0d want 0000 fin 1 st 3", disp, finish, actualState); end
        step(1);
        checks++; if (finish !== 1'b0 || actualState !== 3'd3 || disp !== 16'h0000) begin errors++; $display("FAIL cd_c31: got %h fin %b st %0d want 0000 fin 0 st 3", disp, finish, actualState); end
        pulse_start();
        checks++; if (actualState !== 3'd3) begin errors++; $display("FAIL done_start: st %0d want 3", actualState); end
`endif
        pulse_clear();
        checks++; if (actualState !== 3'd0 || disp !== 16'h0000) begin errors++; $display("FAIL cd_clear: got %h st %0d want 0000 st 0", disp, actualState); end
    endtask

    task automatic test_borrow();
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        pulse_start();
        step(10);
        checks++; if (disp !== 16'h0959) begin errors++; $display("FAIL borrow_1000: got %h want 0959", disp); end
        pulse_clear();
        do_load(4'd0, 4'd1, 4'd0, 4'd0);
        pulse_start();
        step(10);
        checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL borrow_0100: got %h want 0059", disp); end
        pulse_clear();
    endtask

    task automatic test_pause();
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        pulse_start();
        step(4);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++; if (actualState !== 3'd2 || disp !== 16'h0005) begin errors++; $display("FAIL pause_enter: got %h st %0d want 0005 st 2", disp, actualState); end
        step(50);
        checks++; if (actualState !== 3'd2 || disp !== 16'h0005) begin errors++; $display("FAIL pause_hold: got %h st %0d want 0005 st 2", disp, actualState); end
        pulse_start();
        step(5);
        checks++; if (actualState !== 3'd1 || disp !== 16'h0005) begin errors++; $display("FAIL resume_c5: got %h st %0d want 0005 st 1", disp, actualState); end
        step(1);
        checks++; if (disp !== 16'h0004) begin errors++; $display("FAIL resume_c6: got %h want 0004", disp); end
        step(10);
        checks++; if (disp !== 16'h0003) begin errors++; $display("FAIL resume_c16: got %h want 0003", disp); end
        pulse_clear();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++; if (actualState !== 3'd0) begin errors++; $display("FAIL pause_idle: st %0d want 0", actualState); end
    endtask

    task automatic test_clamp();
        do_load(4'hF, 4'hF, 4'hF, 4'hF);
        checks++; if (disp !== 16'h9959) begin errors++; $display("FAIL clamp: got %h want 9959", disp); end
        do_load(4'd3, 4'hA, 4'd6, 4'd7);
        checks++; if (disp !== 16'h3957) begin errors++; $display("FAIL clamp_mix: got %h want 3957", disp); end
        pulse_clear();
        pulse_start();
        step(3);
        checks++; if (actualState !== 3'd0 || disp !== 16'h0000) begin errors++; $display("FAIL start_zero: got %h st %0d want 0000 st 0", disp, actualState); end
    endtask

    task automatic test_priority();
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        pulse_start();
        step(2);
        do_load(4'd0, 4'd0, 4'd0, 4'd9);
        checks++; if (disp !== 16'h0005 || actualState !== 3'd1) begin errors++; $display("FAIL load_in_run: got %h st %0d want 0005 st 1", disp, actualState); end
        start = 1'b1; pause = 1'b1;
        step(1);
        start = 1'b0; pause = 1'b0;
        checks++; if (actualState !== 3'd2) begin errors++; $display("FAIL start_pause: st %0d want 2", actualState); end
        set_mDecimal = 4'd1; set_mUnit = 4'd2; set_sDecimal = 4'd3; set_sUnit = 4'd4;
        clear = 1'b1; load = 1'b1; start = 1'b1;
        step(1);
        clear = 1'b0; load = 1'b0; start = 1'b0;
        checks++; if (disp !== 16'h0000 || actualState !== 3'd0) begin errors++; $display("FAIL clr_ld_st: got %h st %0d want 0000 st 0", disp, actualState); end
    endtask

    task automatic test_reset_mid_run();
        int fin_seen;
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        pulse_start();
        step(15);
        checks++; if (disp !== 16'h0001) begin errors++; $display("FAIL run_c15: got %h want 0001", disp); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (disp !== 16'h0000 || actualState !== 3'd0 || finish !== 1'b0) begin errors++; $display("FAIL mid_reset: got %h st %0d fin %b want 0000 st 0 fin 0", disp, actualState, finish); end
        fin_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (finish === 1'b1 || actualState !== 3'd0) fin_seen++;
        end
        checks++; if (fin_seen !== 0) begin errors++; $display("FAIL post_reset: got %0d bad cycles want 0", fin_seen); end
        pulse_start();
        checks++; if (actualState !== 3'd0) begin errors++; $display("FAIL post_reset_start: st %0d want 0", actualState); end
    endtask

`ifdef TIMER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        do_load(4'd0, 4'd0, 4'd0, 4'd2);
        pulse_start();
        step(19);
        checks++; if (disp !== 16'h0001 || finish !== 1'b0) begin errors++; $display("FAIL ar_c19: got %h fin %b want 0001 fin 0", disp, finish); end
        step(1);
        checks++; if (disp !== 16'h0002 || finish !== 1'b1 || actualState !== 3'd1) begin errors++; $display("FAIL ar_c20: got %h fin %b st %0d want 0002 fin 1 st 1", disp, finish, actualState); end
        step(1);
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL ar_c21: fin %b want 0", finish); end
        step(19);
        checks++; if (disp !== 16'h0002 || finish !== 1'b1 || actualState !== 3'd1) begin errors++; $display("FAIL ar_c40: got %h fin %b st %0d want 0002 fin 1 st 1", disp, finish, actualState); end
        pulse_clear();
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0;
        set_mDecimal = 4'd0; set_mUnit = 4'd0; set_sDecimal = 4'd0; set_sUnit = 4'd0;
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_clamp();
        test_priority();
        test_reset_mid_run();
`ifdef TIMER_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
